mem_1rw_stream_adapter: RTL and testbench

MEM_1RW_STREAM_ADAPTER -- requirements
Module: mem_1rw_stream_adapter

---
 rtl/mem_1rw_stream_adapter.sv | 79 +++++++
 tb/tb_mem_1rw_stream_adapter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_1rw_stream_adapter.sv
// rtl/mem_1rw_stream_adapter.sv - valid/ready request stream to 1rw SRAM with 2-entry read response FIFO
module mem_1rw_stream_adapter #(
  parameter int width_p = 64,
  parameter int els_p = 512,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     ready_i
);

  logic               pending_q, pending_d;
  logic [1:0]         occ_q, occ_d;
  logic               rptr_q, rptr_d;
  logic               wptr_q, wptr_d;
  logic [width_p-1:0] fifo_q [2];

  logic       enq;
  logic       deq;
  logic [2:0] committed;

  // Handshakes, credit check and SRAM pass-through; the credit counts the read
  // already in the SRAM pipe so its response always has a FIFO slot waiting.
  always_comb begin
    v_o        = reset_n_i & (occ_q != 2'd0);
    data_o     = fifo_q[rptr_q];
    deq        = v_o & ready_i;
    enq        = pending_q;
    committed  = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, deq};
    ready_o    = reset_n_i & (committed < 3'd2);
    mem_v_o    = v_i & ready_o;
    mem_w_o    = w_i;
    mem_addr_o = addr_i;
    mem_data_o = data_i;
  end

  // Next-state for the pending flag, occupancy and the modulo-2 pointers.
  always_comb begin
    pending_d = mem_v_o & ~w_i;
    occ_d     = occ_q + {1'b0, enq} - {1'b0, deq};
    rptr_d    = rptr_q ^ deq;
    wptr_d    = wptr_q ^ enq;
  end

  // Control state register; reset drops any read still in the SRAM pipe.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pending_q <= 1'b0;
      occ_q     <= 2'd0;
      rptr_q    <= 1'b0;
      wptr_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      occ_q     <= occ_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
    end
  end

  // Response storage; SRAM read data is captured the cycle after the read.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && enq) begin
      fifo_q[wptr_q] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_mem_1rw_stream_adapter.sv
// tb/tb_mem_1rw_stream_adapter.sv - directed and random checks of mem_1rw_stream_adapter
module tb_mem_1rw_stream_adapter;
  localparam int W  = 16;
  localparam int N  = 32;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          v_i = 1'b0, w_i = 1'b0, ready_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [W-1:0]  data_i = '0;
  logic          ready_o, mem_v_o, mem_w_o, v_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_o, mem_data_i, data_o;

  logic [W-1:0]  sram [N];
  logic [W-1:0]  sram_rd;
  logic [W-1:0]  ref_mem [N];
  logic [W-1:0]  sb [$];
  int            checks = 0;
  int            errors = 0;
  int            outstanding = 0;

  always #5 clk = ~clk;

  mem_1rw_stream_adapter #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .ready_o(ready_o), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .v_o(v_o), .data_o(data_o), .ready_i(ready_i)
  );

  // 1rw SRAM model: read data appears one cycle after the read.
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
      else         sram_rd <= sram[mem_addr_o];
    end
  end
  assign mem_data_i = sram_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic w, input int a, input logic [W-1:0] d, input logic r);
    v_i = v; w_i = w; addr_i = AW'(a); data_i = d; ready_i = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic acc, dlv, wr;
    logic [W-1:0] exp_d;
    int a;

    // Reset: outputs held low even with a request present.
    drv(1, 0, 3, 16'h0, 1);
    tick();
    @(negedge clk);
    chk("rst_v_o", 64'(v_o), 0);
    chk("rst_ready_o", 64'(ready_o), 0);
    chk("rst_mem_v_o", 64'(mem_v_o), 0);
    tick();
    reset_n = 1'b1;
    drv(1, 1, 3, 16'hA5A5, 1);
    @(negedge clk);
    chk("post_rst_ready", 64'(ready_o), 1);
    chk("wr_mem_v", 64'(mem_v_o), 1);
    chk("wr_mem_w", 64'(mem_w_o), 1);
    chk("wr_mem_addr", 64'(mem_addr_o), 3);
    chk("wr_mem_data", 64'(mem_data_o), 64'hA5A5);
    tick();

    // Single read: response exactly two cycles after accept.
    drv(1, 0, 3, 16'h0, 1);
    @(negedge clk);
    chk("rd_accept", 64'(mem_v_o), 1);
    chk("rd_mem_w", 64'(mem_w_o), 0);
    tick();
    drv(0, 0, 0, 16'h0, 1);
    @(negedge clk);
    chk("rd_lat1_v", 64'(v_o), 0);
    tick();
    @(negedge clk);
    chk("rd_lat2_v", 64'(v_o), 1);
    chk("rd_lat2_data", 64'(data_o), 64'hA5A5);
    tick();
    @(negedge clk);
    chk("rd_done_v", 64'(v_o), 0);

    // Fill memory with 0x1000+i.
    for (int i = 0; i < N; i++) begin
      drv(1, 1, i, 16'(16'h1000 + i), 1);
      @(negedge clk);
      chk("fill_ready", 64'(ready_o), 1);
      tick();
    end
    for (int i = 0; i < N; i++) ref_mem[i] = 16'(16'h1000 + i);

    // Backpressure fill: third read stalls until the consumer drains.
    drv(1, 0, 1, 16'h0, 0);
    @(negedge clk);
    chk("bp_c0_ready", 64'(ready_o), 1);
    tick();
    drv(1, 0, 2, 16'h0, 0);
    @(negedge clk);
    chk("bp_c1_ready", 64'(ready_o), 1);
    tick();
    drv(1, 0, 3, 16'h0, 0);
    @(negedge clk);
    chk("bp_c2_ready", 64'(ready_o), 0);
    chk("bp_c2_mem_v", 64'(mem_v_o), 0);
    chk("bp_c2_v", 64'(v_o), 1);
    chk("bp_c2_data", 64'(data_o), 64'h1001);
    tick();
    @(negedge clk);
    chk("bp_c3_ready", 64'(ready_o), 0);
    chk("bp_c3_data_stable", 64'(data_o), 64'h1001);
    tick();
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_c4_v", 64'(v_o), 1);
    chk("bp_c4_data", 64'(data_o), 64'h1001);
    chk("bp_c4_ready", 64'(ready_o), 1);
    chk("bp_c4_mem_v", 64'(mem_v_o), 1);
    tick();
    // occ = 1 with pending read: enqueue and dequeue together.
    drv(0, 0, 0, 16'h0, 1);
    @(negedge clk);
    chk("bp_c5_v", 64'(v_o), 1);
    chk("bp_c5_data", 64'(data_o), 64'h1002);
    chk("bp_c5_ready", 64'(ready_o), 1);
    tick();
    @(negedge clk);
    chk("bp_c6_v", 64'(v_o), 1);
    chk("bp_c6_data", 64'(data_o), 64'h1003);
    tick();
    @(negedge clk);
    chk("bp_c7_v", 64'(v_o), 0);

    // Read then write same address: read returns the old data.
    drv(1, 0, 5, 16'h0, 1);
    tick();
    drv(1, 1, 5, 16'hBEEF, 1);
    @(negedge clk);
    chk("rw_wr_ready", 64'(ready_o), 1);
    tick();
    drv(1, 0, 5, 16'h0, 1);
    @(negedge clk);
    chk("rw_old_v", 64'(v_o), 1);
    chk("rw_old_data", 64'(data_o), 64'h1005);
    tick();
    drv(0, 0, 0, 16'h0, 1);
    @(negedge clk);
    chk("rw_gap_v", 64'(v_o), 0);
    tick();
    @(negedge clk);
    chk("rw_new_v", 64'(v_o), 1);
    chk("rw_new_data", 64'(data_o), 64'hBEEF);
    tick();
    ref_mem[5] = 16'hBEEF;

    // Streaming: 16 back-to-back reads, one response per cycle from cycle 2.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drv(1, 0, i, 16'h0, 1);
      else        drv(0, 0, 0, 16'h0, 1);
      @(negedge clk);
      if (i < 16) chk("st_ready", 64'(ready_o), 1);
      if (i >= 2) begin
        exp_d = (i - 2 == 5) ? 16'hBEEF : 16'(16'h1000 + i - 2);
        chk("st_v", 64'(v_o), 1);
        chk("st_data", 64'(data_o), 64'(exp_d));
      end else begin
        chk("st_v_early", 64'(v_o), 0);
      end
      tick();
    end
    @(negedge clk);
    chk("st_end_v", 64'(v_o), 0);

    // Reset one cycle after a read accept: response is discarded.
    drv(1, 0, 7, 16'h0, 1);
    tick();
    drv(0, 0, 0, 16'h0, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_v", 64'(v_o), 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 64'(ready_o), 1);
    chk("mid_rel_v", 64'(v_o), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("mid_no_resp", 64'(v_o), 0);
    end
    tick();

    // Random mixed traffic against the reference memory and scoreboard.
    for (int n = 0; n < 10000; n++) begin
      a = $urandom_range(0, N - 1);
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a,
          16'($urandom), 1'($urandom_range(0, 3) != 0));
      @(negedge clk);
      acc = v_i & ready_o;
      dlv = v_o & ready_i;
      wr  = w_i;
      chk("rnd_mem_v", 64'(mem_v_o), 64'(acc));
      if (dlv) begin
        chk("rnd_sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("rnd_data", 64'(data_o), 64'(sb.pop_front()));
      end
      if (acc && wr)  ref_mem[a] = data_i;
      if (acc && !wr) sb.push_back(ref_mem[a]);
      outstanding = outstanding + int'(acc && !wr) - int'(dlv);
      chk("rnd_no_overflow", 64'(outstanding <= 2), 1);
      tick();
    end

    // Drain everything still in flight.
    drv(0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (v_o) begin
        chk("drain_sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("drain_data", 64'(data_o), 64'(sb.pop_front()));
      end
      tick();
    end
    chk("drain_empty", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
